// File: rtl/phase_sequencer.sv
// Per-instruction phase controller: walks PH1..PH7 (short ops stop after PH5) and drives selector strobes/codes.
// Start accepted at T: clock_3 @T+3, clock_5 @T+5, clock_7 @T+7, done @T+6/T+8; each stall cycle adds one.
module phase_sequencer #(
  parameter int OP_W         = 4,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      phase,
  output logic            clock_3,
  output logic            clock_5,
  output logic            clock_7,
  output logic [3:0]      select_1,
  output logic [3:0]      select_2,
  output logic [3:0]      select_3
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PH1  = 4'd1;
  localparam logic [3:0] S_PH2  = 4'd2;
  localparam logic [3:0] S_PH3  = 4'd3;
  localparam logic [3:0] S_PH4  = 4'd4;
  localparam logic [3:0] S_PH5  = 4'd5;
  localparam logic [3:0] S_PH6  = 4'd6;
  localparam logic [3:0] S_PH7  = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  // Row layout: {s1, s2, s3, full}
  function automatic logic [12:0] op_row(input logic [2:0] idx);
    case (idx)
      3'd0:    op_row = {4'd0, 4'd0, 4'd0, 1'b0};
      3'd1:    op_row = {4'd5, 4'd2, 4'd1, 1'b1};
      3'd2:    op_row = {4'd2, 4'd1, 4'd0, 1'b0};
      3'd3:    op_row = {4'd4, 4'd2, 4'd1, 1'b1};
      3'd4:    op_row = {4'd3, 4'd3, 4'd2, 1'b1};
      3'd5:    op_row = {4'd4, 4'd5, 4'd2, 1'b1};
      3'd6:    op_row = {4'd6, 4'd6, 4'd0, 1'b0};
      default: op_row = {4'd1, 4'd7, 4'd0, 1'b0};
    endcase
  endfunction

  logic [3:0]  state_q, state_d;
  logic        full_q, full_d;
  logic [3:0]  sel1_q, sel1_d, sel2_q, sel2_d, sel3_q, sel3_d;
  logic [2:0]  phase_q, phase_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0] op_ext;
  logic        op_legal;
  logic [12:0] row;

  assign op_ext   = 32'(op);
  assign op_legal = (op_ext < 32'd8);
  assign row      = op_row(op_legal ? op_ext[2:0] : 3'd0);

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    sel3_d  = sel3_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        sel1_d  = 4'd0;
        sel2_d  = 4'd0;
        sel3_d  = 4'd0;
        if (start) begin
          if (op_legal || !ILLEGAL_TRAP) begin
            state_d = S_PH1;
            {sel1_d, sel2_d, sel3_d, full_d} = row;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PH1, S_PH2, S_PH3, S_PH4, S_PH6: if (!stall) state_d = state_q + 4'd1;
      S_PH5: if (!stall) state_d = full_q ? S_PH6 : S_DONE;
      S_PH7: if (!stall) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d >= S_PH1) && (state_d <= S_PH7);
    done_d  = (state_d == S_DONE);
    phase_d = busy_d ? state_d[2:0] : 3'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      full_q  <= 1'b0;
      sel1_q  <= 4'd0;
      sel2_q  <= 4'd0;
      sel3_q  <= 4'd0;
      phase_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      sel3_q  <= sel3_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Strobes follow the registered phase, so reset clears them without waiting for a clock.
  assign clock_3  = (phase_q == 3'd3) && !stall;
  assign clock_5  = (phase_q == 3'd5) && !stall;
  assign clock_7  = (phase_q == 3'd7) && !stall;
  assign phase    = phase_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign select_1 = sel1_q;
  assign select_2 = sel2_q;
  assign select_3 = sel3_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: instance 0 traps illegal ops, instance 1 runs them as NOP; both share stimulus.
module tb_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op    = 4'd0;
  logic       stall = 1'b0;

  logic       busy_w[2], done_w[2], err_w[2], c3_w[2], c5_w[2], c7_w[2];
  logic [2:0] ph_w[2];
  logic [3:0] s1_w[2], s2_w[2], s3_w[2];

  always #5 clock = ~clock;

  phase_sequencer #(.OP_W(4), .ILLEGAL_TRAP(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .stall(stall),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .phase(ph_w[0]),
    .clock_3(c3_w[0]), .clock_5(c5_w[0]), .clock_7(c7_w[0]),
    .select_1(s1_w[0]), .select_2(s2_w[0]), .select_3(s3_w[0])
  );

  phase_sequencer #(.OP_W(4), .ILLEGAL_TRAP(1'b0)) dut_nt (
    .clock(clock), .reset(reset), .start(start), .op(op), .stall(stall),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .phase(ph_w[1]),
    .clock_3(c3_w[1]), .clock_5(c5_w[1]), .clock_7(c7_w[1]),
    .select_1(s1_w[1]), .select_2(s2_w[1]), .select_3(s3_w[1])
  );

  // Op table: selects and sequence length in phases
  int tbl_s1[8]  = '{0, 5, 2, 4, 3, 4, 6, 1};
  int tbl_s2[8]  = '{0, 2, 1, 2, 3, 5, 6, 7};
  int tbl_s3[8]  = '{0, 1, 0, 1, 2, 2, 0, 0};
  int tbl_len[8] = '{5, 7, 5, 7, 7, 7, 5, 5};

  // Reference: position in the op's phase list (-1 idle, len = done cycle)
  int m_pos[2], m_len[2], m_s1[2], m_s2[2], m_s3[2], m_err[2];
  int t_c3[2], t_c5[2], t_c7[2], t_done[2], t_err[2];
  int n_assert, n_fail, cyc, t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1; m_len[k] = 5; m_err[k] = 0;
      m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0;
    end
  endtask

  task automatic clear_marks();
    for (int k = 0; k < 2; k++) begin
      t_c3[k] = -1; t_c5[k] = -1; t_c7[k] = -1; t_done[k] = -1; t_err[k] = -1;
    end
  endtask

  function automatic bit in_seq(input int k);
    return (m_pos[k] >= 0) && (m_pos[k] < m_len[k]);
  endfunction

  function automatic int exp_phase(input int k);
    return in_seq(k) ? m_pos[k] + 1 : 0;
  endfunction

  task automatic model_step(input int k, input logic s, input logic [3:0] o, input logic st);
    int r;
    m_err[k] = 0;
    if (in_seq(k)) begin
      if (!st) m_pos[k]++;
    end else begin
      m_pos[k] = -1; m_s1[k] = 0; m_s2[k] = 0; m_s3[k] = 0;
      if (s) begin
        if (o < 8 || k == 1) begin
          r = (o < 8) ? int'(o) : 0;
          m_pos[k] = 0; m_len[k] = tbl_len[r];
          m_s1[k] = tbl_s1[r]; m_s2[k] = tbl_s2[r]; m_s3[k] = tbl_s3[r];
        end else begin
          m_err[k] = 1;
        end
      end
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d phase", k), ph_w[k], exp_phase(k));
      chk($sformatf("u%0d busy", k), busy_w[k], in_seq(k));
      chk($sformatf("u%0d done", k), done_w[k], m_pos[k] == m_len[k]);
      chk($sformatf("u%0d err", k), err_w[k], m_err[k]);
      chk($sformatf("u%0d select_1", k), s1_w[k], m_s1[k]);
      chk($sformatf("u%0d select_2", k), s2_w[k], m_s2[k]);
      chk($sformatf("u%0d select_3", k), s3_w[k], m_s3[k]);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d phase", tag, k), ph_w[k], 0);
      chk($sformatf("%s u%0d busy", tag, k), busy_w[k], 0);
      chk($sformatf("%s u%0d done", tag, k), done_w[k], 0);
      chk($sformatf("%s u%0d err", tag, k), err_w[k], 0);
      chk($sformatf("%s u%0d strobes", tag, k), {c3_w[k], c5_w[k], c7_w[k]}, 0);
      chk($sformatf("%s u%0d selects", tag, k), {s1_w[k], s2_w[k], s3_w[k]}, 0);
    end
  endtask

  // Entered just after a rising edge; applies inputs for one full cycle
  task automatic cycle(input logic s, input logic [3:0] o, input logic st);
    start = s; op = o; stall = st;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d clock_3", k), c3_w[k], exp_phase(k) == 3 && !st);
      chk($sformatf("u%0d clock_5", k), c5_w[k], exp_phase(k) == 5 && !st);
      chk($sformatf("u%0d clock_7", k), c7_w[k], exp_phase(k) == 7 && !st);
      if (c3_w[k]) t_c3[k] = cyc;
      if (c5_w[k]) t_c5[k] = cyc;
      if (c7_w[k]) t_c7[k] = cyc;
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k, s, o, st);
    check_regs();
    for (int k = 0; k < 2; k++) begin
      if (done_w[k]) t_done[k] = cyc;
      if (err_w[k]) t_err[k] = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    logic       rs, rst_stall;
    logic [3:0] ro;
    n_assert = 0; n_fail = 0; cyc = 0;
    model_reset();
    clear_marks();

    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    check_regs();

    // Full op PUSH_EBP
    clear_marks(); t0 = cyc;
    cycle(1'b1, 4'd1, 1'b0);
    chk("t1 select_1@T1", s1_w[0], 5);
    idle(9);
    chk("t1 clock_3 time", t_c3[0], t0 + 3);
    chk("t1 clock_5 time", t_c5[0], t0 + 5);
    chk("t1 clock_7 time", t_c7[0], t0 + 7);
    chk("t1 done time", t_done[0], t0 + 8);

    // Short op MOV_EBP_ESP
    clear_marks(); t0 = cyc;
    cycle(1'b1, 4'd2, 1'b0);
    idle(8);
    chk("t2 clock_5 time", t_c5[0], t0 + 5);
    chk("t2 done time", t_done[0], t0 + 6);
    chk("t2 clock_7 never", t_c7[0], -1);

    // RET with stall over phase 3
    clear_marks(); t0 = cyc;
    cycle(1'b1, 4'd5, 1'b0);
    idle(2);
    cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b0, 4'd0, 1'b1);
    idle(7);
    chk("t3 clock_3 time", t_c3[0], t0 + 5);
    chk("t3 clock_5 time", t_c5[0], t0 + 7);
    chk("t3 done time", t_done[0], t0 + 10);

    // Illegal op: trapped on u0, NOP on u1
    clear_marks(); t0 = cyc;
    cycle(1'b1, 4'd9, 1'b0);
    idle(7);
    chk("t4 err time", t_err[0], t0 + 1);
    chk("t4 no clock_3", t_c3[0], -1);
    chk("t4 no done", t_done[0], -1);
    chk("t4 nop done time", t_done[1], t0 + 6);
    chk("t4 nop no err", t_err[1], -1);

    // Back-to-back start held in DONE, stray start in PH4
    clear_marks(); t0 = cyc;
    cycle(1'b1, 4'd1, 1'b0);
    idle(7);
    chk("t5 in done", done_w[0], 1);
    cycle(1'b1, 4'd4, 1'b0);
    chk("t5 ph1 no gap", ph_w[0], 1);
    chk("t5 selects", {s1_w[0], s2_w[0], s3_w[0]}, {4'd3, 4'd3, 4'd2});
    clear_marks();
    idle(3);
    cycle(1'b1, 4'd6, 1'b0);
    chk("t5 start ignored", ph_w[0], 5);
    idle(6);
    chk("t5 done time", t_done[0], t0 + 16);

    // Reset in PH6 of POP_EBP, then MOV_EBX
    t0 = cyc;
    cycle(1'b1, 4'd3, 1'b0);
    idle(5);
    chk("t6 at ph6", ph_w[0], 6);
    reset = 1'b1;
    #1;
    chk_zero("t6 async reset");
    model_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    cyc++;
    clear_marks(); t0 = cyc;
    cycle(1'b1, 4'd7, 1'b0);
    idle(7);
    chk("t6 done time", t_done[0], t0 + 6);
    chk("t6 select_2 idle", s2_w[0], 0);

    // Random traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      rs = ($urandom_range(0, 2) == 0);
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rst_stall = ($urandom_range(0, 3) == 0);
      cycle(rs, ro, rst_stall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
